// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - shares one single-outstanding memory bus between fetch (I) and load/store (D)
// D wins by default; a saturating wait counter hands the bus to a starved fetch.
module imem_dmem_arbiter #(
  parameter int XLEN           = 32,
  parameter int BUS_WID        = 64,
  parameter int FETCH_MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [XLEN-1:0]      i_addr,
  input  logic                 i_flush,
  output logic                 i_gnt,
  output logic                 i_resp,
  output logic [BUS_WID-1:0]   i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [XLEN-1:0]      d_addr,
  input  logic [BUS_WID-1:0]   d_wdata,
  input  logic [BUS_WID/8-1:0] d_be,
  output logic                 d_gnt,
  output logic                 d_resp,
  output logic [BUS_WID-1:0]   d_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [BUS_WID-1:0]   mem_wdata,
  output logic [BUS_WID/8-1:0] mem_be,
  input  logic                 mem_resp,
  input  logic [BUS_WID-1:0]   mem_rdata
);

  localparam int BE_W = BUS_WID / 8;
  localparam int OFFS = $clog2(BE_W);
  localparam int CW   = $clog2(FETCH_MAX_WAIT + 1);
  localparam logic [CW-1:0]   WAIT_MAX  = CW'(FETCH_MAX_WAIT);
  localparam logic [XLEN-1:0] ADDR_MASK = ~XLEN'((1 << OFFS) - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_I_DROP,
    BUSY_D
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          bus_free;
  logic          grant_i, grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // The bus frees up in the very cycle the outstanding response returns.
  always_comb begin
    bus_free = (state_q == IDLE) | mem_resp;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    if (!rst && bus_free) begin
      if (i_req && d_req) begin
        if (wait_cnt_q >= WAIT_MAX) grant_i = 1'b1;
        else                        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!i_req || grant_i) begin
      wait_cnt_d = '0;
    end else if (grant_d && (wait_cnt_q < WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  // A fresh grant outranks both the response and a flush of the old fetch.
  always_comb begin
    state_d = state_q;
    if (grant_i) begin
      state_d = BUSY_I;
    end else if (grant_d) begin
      state_d = BUSY_D;
    end else if (mem_resp) begin
      state_d = IDLE;
    end else if ((state_q == BUSY_I) && i_flush) begin
      state_d = BUSY_I_DROP;
    end
  end

  always_comb begin
    i_gnt     = grant_i;
    d_gnt     = grant_d;
    mem_req   = grant_i | grant_d;
    mem_we    = grant_d & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (grant_i) begin
      mem_addr = i_addr & ADDR_MASK;
    end else if (grant_d) begin
      mem_addr  = d_addr & ADDR_MASK;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end
  end

  always_comb begin
    i_resp  = ~rst & mem_resp & (state_q == BUSY_I) & ~i_flush;
    d_resp  = ~rst & mem_resp & (state_q == BUSY_D);
    i_rdata = mem_rdata;
    d_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - directed and randomized checks of imem_dmem_arbiter
module tb_imem_dmem_arbiter;
  localparam int XLEN = 32;
  localparam int BUS_WID = 64;
  localparam int FMW = 4;

  logic clk = 1'b0;
  logic rst;
  logic i_req, i_flush, i_gnt, i_resp;
  logic [XLEN-1:0] i_addr;
  logic [BUS_WID-1:0] i_rdata;
  logic d_req, d_we, d_gnt, d_resp;
  logic [XLEN-1:0] d_addr;
  logic [BUS_WID-1:0] d_wdata, d_rdata;
  logic [BUS_WID/8-1:0] d_be;
  logic mem_req, mem_we, mem_resp;
  logic [XLEN-1:0] mem_addr;
  logic [BUS_WID-1:0] mem_wdata, mem_rdata;
  logic [BUS_WID/8-1:0] mem_be;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit is_d;
    bit squashed;
  } txn_t;

  imem_dmem_arbiter #(.XLEN(XLEN), .BUS_WID(BUS_WID), .FETCH_MAX_WAIT(FMW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_resp(i_resp), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_inputs;
    i_req = 0; i_addr = '0; i_flush = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_resp = 0; mem_rdata = '0;
  endtask

  task automatic test_reset;
    tick; rst = 1; i_req = 1; d_req = 1; mem_resp = 1; settle;
    total++;
    if ({mem_req, i_gnt, d_gnt, i_resp, d_resp} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=00000", {mem_req, i_gnt, d_gnt, i_resp, d_resp});
    end
    tick; idle_inputs; rst = 0; settle;
    total++;
    if ({mem_req, i_resp, d_resp} !== 3'b0) begin
      bad++; $display("FAIL reset_idle got=%b exp=000", {mem_req, i_resp, d_resp});
    end
  endtask

  task automatic test_i_only;
    tick; i_req = 1; i_addr = 32'h204; settle;
    total++;
    if ({i_gnt, d_gnt, mem_req} !== 3'b101) begin
      bad++; $display("FAIL ionly_gnt got=%b exp=101", {i_gnt, d_gnt, mem_req});
    end
    total++;
    if (mem_addr !== 32'h200 || mem_we !== 1'b0 || mem_be !== 8'h0 || mem_wdata !== 64'h0) begin
      bad++; $display("FAIL ionly_fields addr=%h we=%b be=%h wd=%h exp addr=200 rest 0", mem_addr, mem_we, mem_be, mem_wdata);
    end
    tick; i_req = 0; settle;
    total++;
    if ({mem_req, i_resp} !== 2'b00) begin
      bad++; $display("FAIL ionly_wait got=%b exp=00", {mem_req, i_resp});
    end
    tick; mem_resp = 1; mem_rdata = 64'hAA; i_req = 1; i_addr = 32'h208; settle;
    total++;
    if (i_resp !== 1'b1 || i_rdata !== 64'hAA) begin
      bad++; $display("FAIL ionly_resp resp=%b data=%h exp 1/aa", i_resp, i_rdata);
    end
    total++;
    if (i_gnt !== 1'b1 || mem_addr !== 32'h208) begin
      bad++; $display("FAIL ionly_regrant gnt=%b addr=%h exp 1/208", i_gnt, mem_addr);
    end
    tick; mem_resp = 0; i_req = 0;
    tick; mem_resp = 1; mem_rdata = 64'h55; settle;
    total++;
    if (i_resp !== 1'b1 || i_rdata !== 64'h55) begin
      bad++; $display("FAIL ionly_resp2 resp=%b data=%h exp 1/55", i_resp, i_rdata);
    end
    tick; mem_resp = 0; settle;
    total++;
    if (i_resp !== 1'b0) begin
      bad++; $display("FAIL ionly_noresp got=%b exp=0", i_resp);
    end
  endtask

  task automatic test_contention;
    bit exp_i;
    for (int g = 1; g <= 6; g++) begin
      tick; i_req = 1; i_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h80;
      mem_resp = (g > 1); mem_rdata = 64'(g); settle;
      exp_i = (g == 5);
      total++;
      if ({i_gnt, d_gnt} !== {exp_i, ~exp_i}) begin
        bad++; $display("FAIL contention_gnt%0d got=%b exp=%b", g, {i_gnt, d_gnt}, {exp_i, ~exp_i});
      end
      if (g > 1) begin
        total++;
        if ({i_resp, d_resp} !== ((g == 6) ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL contention_resp%0d got=%b exp=%b", g, {i_resp, d_resp}, (g == 6) ? 2'b10 : 2'b01);
        end
      end
    end
    tick; i_req = 0; d_req = 0; mem_resp = 1; settle;
    total++;
    if ({mem_req, i_resp, d_resp} !== 3'b001) begin
      bad++; $display("FAIL contention_drain got=%b exp=001", {mem_req, i_resp, d_resp});
    end
    tick; mem_resp = 0;
  endtask

  task automatic test_write;
    tick; d_req = 1; d_we = 1; d_addr = 32'h1005; d_be = 8'h0F; d_wdata = 64'h1234; settle;
    total++;
    if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_be !== 8'h0F || mem_wdata !== 64'h1234 || mem_addr !== 32'h1000) begin
      bad++; $display("FAIL write_fields gnt=%b we=%b be=%h wd=%h addr=%h exp 1/1/0f/1234/1000", d_gnt, mem_we, mem_be, mem_wdata, mem_addr);
    end
    tick; d_req = 0; d_we = 0;
    tick; mem_resp = 1; settle;
    total++;
    if ({i_resp, d_resp} !== 2'b01) begin
      bad++; $display("FAIL write_ack got=%b exp=01", {i_resp, d_resp});
    end
    tick; mem_resp = 0;
  endtask

  task automatic test_flush;
    tick; i_req = 1; i_addr = 32'h300; settle;
    total++;
    if (i_gnt !== 1'b1) begin
      bad++; $display("FAIL flush_gnt got=%b exp=1", i_gnt);
    end
    tick; i_addr = 32'h400; i_flush = 1; settle;
    total++;
    if (i_gnt !== 1'b0) begin
      bad++; $display("FAIL flush_busy got=%b exp=0", i_gnt);
    end
    tick; i_flush = 0; mem_resp = 1; mem_rdata = 64'h11; settle;
    total++;
    if (i_resp !== 1'b0 || i_gnt !== 1'b1 || mem_addr !== 32'h400) begin
      bad++; $display("FAIL flush_drop resp=%b gnt=%b addr=%h exp 0/1/400", i_resp, i_gnt, mem_addr);
    end
    tick; i_req = 0; mem_resp = 0;
    tick; mem_resp = 1; mem_rdata = 64'h22; settle;
    total++;
    if (i_resp !== 1'b1 || i_rdata !== 64'h22) begin
      bad++; $display("FAIL flush_newdata resp=%b data=%h exp 1/22", i_resp, i_rdata);
    end
    tick; mem_resp = 0; i_req = 1; i_addr = 32'h500;
    tick; i_req = 0; mem_resp = 1; i_flush = 1; settle;
    total++;
    if (i_resp !== 1'b0) begin
      bad++; $display("FAIL flush_samecycle got=%b exp=0", i_resp);
    end
    tick; idle_inputs;
  endtask

  task automatic test_reset_midop;
    tick; d_req = 1; d_addr = 32'h40; settle;
    total++;
    if (d_gnt !== 1'b1) begin
      bad++; $display("FAIL midrst_gnt got=%b exp=1", d_gnt);
    end
    tick; rst = 1; settle;
    total++;
    if ({mem_req, d_gnt, d_resp} !== 3'b0) begin
      bad++; $display("FAIL midrst_outputs got=%b exp=000", {mem_req, d_gnt, d_resp});
    end
    tick; rst = 0; d_req = 0; mem_resp = 1; settle;
    total++;
    if ({i_resp, d_resp} !== 2'b00) begin
      bad++; $display("FAIL midrst_stray got=%b exp=00", {i_resp, d_resp});
    end
    tick; mem_resp = 0; d_req = 1; d_addr = 32'h48; settle;
    total++;
    if (d_gnt !== 1'b1 || mem_addr !== 32'h48) begin
      bad++; $display("FAIL midrst_regrant gnt=%b addr=%h exp 1/48", d_gnt, mem_addr);
    end
    tick; d_req = 0; mem_resp = 1; settle;
    total++;
    if (d_resp !== 1'b1) begin
      bad++; $display("FAIL midrst_resp got=%b exp=1", d_resp);
    end
    tick; idle_inputs;
  endtask

  task automatic test_random;
    txn_t outq[$];
    txn_t t;
    int resp_in, i_wait;
    bit free, exp_ig, exp_dg, exp_ir, exp_dr, i_taken, d_taken;
    logic [XLEN-1:0] exp_addr;
    resp_in = 0; i_wait = 0; i_taken = 0; d_taken = 0;
    tick; rst = 1; idle_inputs;
    tick; rst = 0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      if (i_taken) i_req = 0;
      if (d_taken) d_req = 0;
      if (!i_req && $urandom_range(0, 1) == 1) begin
        i_req = 1; i_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1; d_we = 1'($urandom); d_addr = $urandom;
        d_wdata = {$urandom, $urandom}; d_be = 8'($urandom);
      end
      i_flush = ($urandom_range(0, 5) == 0);
      mem_resp = (outq.size() != 0) ? (resp_in == 0) : ($urandom_range(0, 9) == 0);
      mem_rdata = {$urandom, $urandom};
      settle;

      free = (outq.size() == 0) || mem_resp;
      exp_ig = 0; exp_dg = 0;
      if (free) begin
        if (i_req && d_req) begin
          if (i_wait >= FMW) exp_ig = 1; else exp_dg = 1;
        end else begin
          exp_ig = i_req; exp_dg = d_req;
        end
      end
      exp_ir = 0; exp_dr = 0;
      if (mem_resp && outq.size() != 0) begin
        exp_dr = outq[0].is_d;
        exp_ir = !outq[0].is_d && !outq[0].squashed && !i_flush;
      end

      total++;
      if ({i_gnt, d_gnt, mem_req} !== {exp_ig, exp_dg, exp_ig | exp_dg}) begin
        bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, {i_gnt, d_gnt, mem_req}, {exp_ig, exp_dg, exp_ig | exp_dg});
      end
      total++;
      if ({i_resp, d_resp} !== {exp_ir, exp_dr}) begin
        bad++; $display("FAIL rnd_resp cyc=%0d got=%b exp=%b", c, {i_resp, d_resp}, {exp_ir, exp_dr});
      end
      if (exp_ir || exp_dr) begin
        total++;
        if ((exp_ir ? i_rdata : d_rdata) !== mem_rdata) begin
          bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, exp_ir ? i_rdata : d_rdata, mem_rdata);
        end
      end
      if (exp_ig || exp_dg) begin
        exp_addr = (exp_ig ? i_addr : d_addr) & ~32'h7;
        total++;
        if (mem_addr !== exp_addr || mem_we !== (exp_dg & d_we) ||
            mem_be !== (exp_dg ? d_be : 8'h0) || mem_wdata !== (exp_dg ? d_wdata : 64'h0)) begin
          bad++; $display("FAIL rnd_fields cyc=%0d addr=%h/%h we=%b be=%h wd=%h", c, mem_addr, exp_addr, mem_we, mem_be, mem_wdata);
        end
      end

      if (mem_resp && outq.size() != 0) void'(outq.pop_front());
      else if (outq.size() != 0) resp_in--;
      if (i_flush && outq.size() != 0 && !outq[0].is_d) begin
        t = outq.pop_front(); t.squashed = 1; outq.push_front(t);
      end
      if (exp_ig || exp_dg) begin
        t.is_d = exp_dg; t.squashed = 0; outq.push_back(t);
        resp_in = $urandom_range(0, 3);
      end
      if (!i_req || exp_ig) i_wait = 0;
      else if (exp_dg && i_wait < FMW) i_wait++;
      i_taken = exp_ig; d_taken = exp_dg;
    end
    tick; idle_inputs; mem_resp = (outq.size() != 0);
    tick; mem_resp = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs;
    test_reset;
    test_i_only;
    test_contention;
    test_write;
    test_flush;
    test_reset_midop;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
